// File: rtl/dac_sample_sched.sv
// Sample scheduler between a streaming producer and the R2R/PWM DAC core: buffers samples,
// primes before playback and flags underruns. Optional macro: DAC_SCHED_UNDERRUN_CNT_EN.
module dac_sample_sched #(
  parameter int DAC_BITS    = 14,
  parameter int FIFO_DEPTH  = 8,
  parameter int PRIME_LEVEL = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [DAC_BITS-1:0]           s_data,
  input  logic                          val_req,
  output logic [DAC_BITS-1:0]           dac_val,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          underrun,
  input  logic                          underrun_clr,
  output logic                          running
`ifdef DAC_SCHED_UNDERRUN_CNT_EN
  ,
  output logic [15:0]                   underrun_cnt
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [DAC_BITS-1:0] MID     = {1'b1, {(DAC_BITS-1){1'b0}}};
  localparam logic [LW-1:0]       DEPTH_L = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0]       PRIME_L = LW'(PRIME_LEVEL);

  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

  state_t                state_q, state_d;
  logic [DAC_BITS-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [LW-1:0]         level_q;
  logic                  full, empty, push, pop, under_ev;

  assign full  = (level_q == DEPTH_L);
  assign empty = (level_q == '0);

  // Ready depends only on registered occupancy, so a pop never frees a slot in the same cycle.
  assign s_ready  = enable & ~full & (state_q != IDLE);
  assign push     = s_valid & s_ready;
  assign pop      = enable & (state_q == RUN) & val_req & ~empty;
  assign under_ev = enable & (state_q == RUN) & val_req & empty;

  // NOTE: every variable written in always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable) state_d = PRIME;
      PRIME:   if (level_q >= PRIME_L) state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = IDLE;
    endcase
    if (!enable) state_d = IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level_q  <= '0;
      dac_val  <= MID;
      underrun <= 1'b0;
    end else begin
      state_q <= state_d;
      if (!enable) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        level_q <= '0;
        dac_val <= MID;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop) begin
          rd_ptr  <= rd_ptr + AW'(1);
          dac_val <= mem[rd_ptr];
        end
        case ({push, pop})
          2'b10:   level_q <= level_q + LW'(1);
          2'b01:   level_q <= level_q - LW'(1);
          default: level_q <= level_q;
        endcase
      end
      // A new underrun takes priority over a coincident clear.
      if (under_ev)          underrun <= 1'b1;
      else if (underrun_clr) underrun <= 1'b0;
    end
  end

  // NOTE: the sample storage has no reset; pointers and level define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_data;
  end

`ifdef DAC_SCHED_UNDERRUN_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      underrun_cnt <= '0;
    end else if (under_ev) begin
      if (underrun_clr)                underrun_cnt <= 16'd1;
      else if (underrun_cnt != 16'hFFFF) underrun_cnt <= underrun_cnt + 16'd1;
    end else if (underrun_clr) begin
      underrun_cnt <= '0;
    end
  end
`endif

  assign fifo_level = level_q;
  assign running    = (state_q == RUN);

endmodule

// File: tb/tb_dac_sample_sched.sv
// Self-checking bench for dac_sample_sched: directed scenarios followed by random traffic,
// all compared against a queue-based reference model.
module tb_dac_sample_sched;

  localparam int          DEPTH = 8;
  localparam int          PLVL  = 4;
  localparam logic [13:0] MID   = 14'h2000;

  logic        clk = 1'b0;
  logic        rst, enable, s_valid, val_req, underrun_clr;
  logic [13:0] s_data;
  logic        s_ready, underrun, running;
  logic [13:0] dac_val;
  logic [3:0]  fifo_level;
`ifdef DAC_SCHED_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt;
`endif

  dac_sample_sched #(.DAC_BITS(14), .FIFO_DEPTH(DEPTH), .PRIME_LEVEL(PLVL)) dut (
    .clk(clk), .rst(rst), .enable(enable), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .val_req(val_req), .dac_val(dac_val), .fifo_level(fifo_level),
    .underrun(underrun), .underrun_clr(underrun_clr), .running(running)
`ifdef DAC_SCHED_UNDERRUN_CNT_EN
    , .underrun_cnt(underrun_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_asserts = 0;
  int n_fail    = 0;

  // Reference model: the buffer is a queue, the session is a phase number (0 idle, 1 prime, 2 run).
  logic [13:0] q[$];
  int          m_phase = 0;
  logic [13:0] m_dac   = MID;
  logic        m_und   = 1'b0;
  int          m_cnt   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic en, input logic sv, input logic [13:0] sd,
                      input logic vr, input logic cl);
    bit ready, push, pop, ev;
    rst = r; enable = en; s_valid = sv; s_data = sd; val_req = vr; underrun_clr = cl;
    #1;
    ready = en && (m_phase != 0) && (q.size() < DEPTH);
    check("s_ready", {31'd0, s_ready}, {31'd0, ready});
    push = sv && ready;
    ev   = en && (m_phase == 2) && vr && (q.size() == 0);
    pop  = en && (m_phase == 2) && vr && (q.size() > 0);
    if (r) begin
      q.delete(); m_phase = 0; m_dac = MID; m_und = 1'b0; m_cnt = 0;
    end else begin
      if (!en) begin
        q.delete(); m_phase = 0; m_dac = MID;
      end else begin
        if (m_phase == 0)                       m_phase = 1;
        else if (m_phase == 1 && q.size() >= PLVL) m_phase = 2;
        if (pop)  m_dac = q.pop_front();
        if (push) q.push_back(sd);
      end
      if (ev) begin
        m_und = 1'b1;
        m_cnt = cl ? 1 : ((m_cnt == 65535) ? 65535 : m_cnt + 1);
      end else if (cl) begin
        m_und = 1'b0; m_cnt = 0;
      end
    end
    @(posedge clk);
    #1;
    check("dac_val",    {18'd0, dac_val},    {18'd0, m_dac});
    check("fifo_level", {28'd0, fifo_level}, q.size());
    check("underrun",   {31'd0, underrun},   {31'd0, m_und});
    check("running",    {31'd0, running},    {31'd0, (m_phase == 2)});
`ifdef DAC_SCHED_UNDERRUN_CNT_EN
    check("underrun_cnt", {16'd0, underrun_cnt}, m_cnt);
`endif
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; s_valid = 1'b0; s_data = '0; val_req = 1'b0; underrun_clr = 1'b0;

    // Reset state
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    check("rst_dac", {18'd0, dac_val}, {18'd0, MID});
    check("rst_level", {28'd0, fifo_level}, 0);

    // Prime with four samples, then playback in order
    step(0, 1, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) step(0, 1, 1, 14'(i << 8), 0, 0);
    check("prime_not_running", {31'd0, running}, 0);
    step(0, 1, 0, 0, 0, 0);
    check("run_entered", {31'd0, running}, 1);
    for (int i = 1; i <= 4; i++) begin
      step(0, 1, 0, 0, 1, 0);
      check("play_order", {18'd0, dac_val}, i << 8);
      step(0, 1, 0, 0, 0, 0);
    end

    // Three underruns with an empty buffer
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 0, 1, 0);
      step(0, 1, 0, 0, 0, 0);
    end
    check("underrun_hold", {18'd0, dac_val}, 14'h0400);
    check("underrun_flag", {31'd0, underrun}, 1);
`ifdef DAC_SCHED_UNDERRUN_CNT_EN
    check("underrun_cnt3", {16'd0, underrun_cnt}, 3);
`endif
    step(0, 1, 0, 0, 0, 1);

    // Full buffer with simultaneous pop: push refused that cycle, accepted the next
    for (int i = 0; i < 8; i++) step(0, 1, 1, 14'($urandom), 0, 0);
    step(0, 1, 1, 14'h0AAA, 1, 0);
    check("full_pop_level", {28'd0, fifo_level}, 7);
    step(0, 1, 1, 14'h0BBB, 0, 0);
    check("refill_level", {28'd0, fifo_level}, 8);
    for (int i = 0; i < 8; i++) step(0, 1, 0, 0, 1, 0);
    step(0, 1, 0, 0, 0, 1);

    // Empty buffer, push and request together: underrun, word stored not bypassed
    step(0, 1, 1, 14'h1234, 1, 0);
    check("bypass_level", {28'd0, fifo_level}, 1);
    check("bypass_flag", {31'd0, underrun}, 1);
    check("bypass_dac", {18'd0, dac_val}, 14'h0BBB);
    step(0, 1, 0, 0, 1, 0);
    check("stored_word", {18'd0, dac_val}, 14'h1234);

    // Drop enable with five buffered samples
    for (int i = 0; i < 5; i++) step(0, 1, 1, 14'(16'h0500 + i), 0, 0);
    step(0, 0, 0, 0, 0, 0);
    check("flush_level", {28'd0, fifo_level}, 0);
    check("flush_dac", {18'd0, dac_val}, {18'd0, MID});
    check("flush_running", {31'd0, running}, 0);

    // Reset mid-playback with three samples buffered
    step(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 1, 14'(16'h0700 + i), 0, 0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 1, 0);
    check("pre_rst_level", {28'd0, fifo_level}, 3);
    step(1, 1, 1, 14'h3FFF, 1, 0);
    check("mid_rst_level", {28'd0, fifo_level}, 0);
    check("mid_rst_dac", {18'd0, dac_val}, {18'd0, MID});

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      step(($urandom % 250) == 0, ($urandom % 60) != 0, 1'($urandom), 14'($urandom),
           ($urandom % 3) == 0, ($urandom % 25) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
